// File: rtl/uart_fifo.sv
// Bus-mapped UART with RX/TX FIFOs, runtime baud divisor, sticky error flags and a level irq.
// Registers: 0 data, 1 status, 2 control, 3 divisor.
//
// state    | meaning
// RX_IDLE  | line idle, watching for a falling edge
// RX_START | timing to the middle of the start bit
// RX_DATA  | sampling character bits, LSB first
// RX_STOP  | sampling the stop bit
// RX_BRK   | framing error, waiting for the line to return high
// TX_IDLE  | nothing to send, tx high
// TX_START | driving the start bit
// TX_DATA  | shifting character bits out, LSB first
// TX_STOP  | driving the stop bit
module uart_fifo #(
  parameter int CLK_DIV   = 434,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int DATA_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic        rw,
  input  logic        uds,
  input  logic        lds,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  input  logic        rx,
  output logic        tx,
  output logic        rx_avail,
  output logic        tx_active,
  output logic        irq
);

  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic                 acc, bus_wr, rx_pop, rx_push, rx_push_req, rx_ovr_set, frame_err_set;
  logic                 tx_push, tx_pop, tx_ovr_set, flush, ctrl_wr, clr;
  logic                 rx_empty, rx_full, tx_empty, tx_full;
  logic [15:0]          div_q, div_eff, status;
  logic                 rx_ie_q, txe_ie_q, rx_ovr_q, frame_err_q, tx_ovr_q, irq_q;
  logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
  logic [RXA-1:0]       rx_wp_q, rx_rp_q;
  logic [TXA-1:0]       tx_wp_q, tx_rp_q;
  logic [RXA:0]         rx_cnt_q;
  logic [TXA:0]         tx_cnt_q;

  rx_state_e            rx_state_q, rx_state_d;
  logic [15:0]          rx_tmr_q, rx_tmr_d, rx_div_q, rx_div_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;

  tx_state_e            tx_state_q, tx_state_d;
  logic [15:0]          tx_tmr_q, tx_tmr_d, tx_div_q, tx_div_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d, tx_act_q, tx_act_d;

  assign acc      = uds | lds;
  assign bus_wr   = acc & ~rw;
  assign ctrl_wr  = bus_wr & lds & (addr == 2'd2);
  assign clr      = ctrl_wr & data_write[2];
  assign flush    = ctrl_wr & data_write[3];
  assign div_eff  = (div_q < 16'd2) ? 16'd2 : div_q;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RXA+1)'(RX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (TXA+1)'(TX_DEPTH));

  // A pop on the same edge frees the slot, so a push into a full FIFO is not an overrun then.
  assign rx_pop     = acc & rw & (addr == 2'd0) & ~rx_empty;
  assign rx_push    = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_push_req & rx_full & ~rx_pop;
  assign tx_push    = bus_wr & lds & (addr == 2'd0) & ~tx_full;
  assign tx_ovr_set = bus_wr & lds & (addr == 2'd0) & tx_full;

  assign status = {8'(rx_cnt_q), tx_ovr_q, frame_err_q, rx_ovr_q, tx_act_q,
                   tx_empty, tx_full, rx_full, ~rx_empty};

  always_comb begin
    data_read = '0;
    if (acc) begin
      case (addr)
        2'd0:    if (!rx_empty) data_read[DATA_BITS-1:0] = rx_mem_q[rx_rp_q];
        2'd1:    data_read = status;
        2'd2:    data_read = {14'b0, txe_ie_q, rx_ie_q};
        default: data_read = div_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_shift_q;
    if (tx_push) tx_mem_q[tx_wp_q] <= data_write[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
    end else if (flush) begin
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + (RXA+1)'(rx_push) - (RXA+1)'(rx_pop);
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + (TXA+1)'(tx_push) - (TXA+1)'(tx_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= 16'(CLK_DIV);
      rx_ie_q     <= 1'b0;
      txe_ie_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovr_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (bus_wr && addr == 2'd3) begin
        if (uds) div_q[15:8] <= data_write[15:8];
        if (lds) div_q[7:0]  <= data_write[7:0];
      end
      if (ctrl_wr) begin
        rx_ie_q  <= data_write[0];
        txe_ie_q <= data_write[1];
      end
      rx_ovr_q    <= (rx_ovr_q & ~clr) | rx_ovr_set;
      frame_err_q <= (frame_err_q & ~clr) | frame_err_set;
      tx_ovr_q    <= (tx_ovr_q & ~clr) | tx_ovr_set;
      irq_q       <= (rx_ie_q & ~rx_empty) | (txe_ie_q & tx_empty & ~tx_act_q)
                   | rx_ovr_q | frame_err_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_tmr_q <= '0; rx_div_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
      tx_state_q <= TX_IDLE; tx_tmr_q <= '0; tx_div_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0;
      tx_q <= 1'b1; tx_act_q <= 1'b0;
    end else begin
      rx_s1_q <= rx; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      rx_state_q <= rx_state_d; rx_tmr_q <= rx_tmr_d; rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d; tx_tmr_q <= tx_tmr_d; tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d; tx_shift_q <= tx_shift_d;
      tx_q <= tx_d; tx_act_q <= tx_act_d;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_tmr_d      = (rx_tmr_q == '0) ? rx_tmr_q : rx_tmr_q - 16'd1;
    rx_div_d      = rx_div_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push_req   = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = RX_START;
        rx_div_d   = div_eff;
        rx_tmr_d   = (div_eff >> 1) - 16'd1;
      end
      RX_START: if (rx_tmr_q == '0) begin
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        rx_tmr_d   = rx_div_q - 16'd1;
        rx_bit_d   = '0;
      end
      RX_DATA: if (rx_tmr_q == '0) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_tmr_d   = rx_div_q - 16'd1;
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tmr_q == '0) begin
        rx_push_req   = rx_s2_q;
        frame_err_set = ~rx_s2_q;
        rx_state_d    = rx_s2_q ? RX_IDLE : RX_BRK;
      end
      RX_BRK:  if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = (tx_tmr_q == '0) ? tx_tmr_q : tx_tmr_q - 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_act_d   = tx_act_q;
    tx_pop     = 1'b0;
    // Reloading straight out of STOP keeps back-to-back frames gapless.
    if ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_tmr_q == '0)) begin
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_d = TX_START;
        tx_div_d   = div_eff;
        tx_tmr_d   = div_eff - 16'd1;
        tx_shift_d = tx_mem_q[tx_rp_q];
        tx_d       = 1'b0;
        tx_act_d   = 1'b1;
      end else begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
        tx_act_d   = 1'b0;
      end
    end else if (tx_tmr_q == '0) begin
      tx_tmr_d = tx_div_q - 16'd1;
      if (tx_state_q == TX_START) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end else if (tx_bit_q == LAST_BIT) begin
        tx_state_d = TX_STOP;
        tx_d       = 1'b1;
      end else begin
        tx_bit_d   = tx_bit_q + 3'd1;
        tx_shift_d = tx_shift_q >> 1;
        tx_d       = tx_shift_q[1];
      end
    end
  end

  assign tx        = tx_q;
  assign tx_active = tx_act_q;
  assign rx_avail  = ~rx_empty;
  assign irq       = irq_q;

endmodule
